// File: rtl/lrn_pkg.sv
// Shared types for the LRN padding unit.
//   pad_state_t : control states of the border zero-fill sequencer
//   ST_W        : encoded width of pad_state_t
package lrn_pkg;

    localparam int unsigned ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE = 2'd0,
        PAD  = 2'd1,
        DONE = 2'd2
    } pad_state_t;

endpackage

// File: rtl/lrn_pad_scan_counter.sv
// Nested n/m/x/y scan counters plus the running write address for the
// padded LRN output buffer. Walks the buffer in linear address order
// (n, m, x, y with y fastest) and jumps over the interior rows of each
// interior column, so only border addresses are produced.
//
// Ports
//   core_clk, reset : clock, asynchronous active-high reset
//   clear           : synchronous restart of the scan at address 0
//   advance         : the current beat was accepted; step to the next one
//   dim4..dim1      : latched N, M, E, F
//   pad             : latched P (>= 1 whenever advance is asserted)
//   ep, fp          : latched padded height / width
//   addr            : current border address
//   border_next     : the row after y in this column is still a border row
//   skip_amount     : address increment applied on the next advance
//   last            : current position is the final border beat
module lrn_pad_scan_counter #(
    parameter int unsigned N_WIDTH        = 2,
    parameter int unsigned M_WIDTH        = 10,
    parameter int unsigned E_WIDTH        = 6,
    parameter int unsigned F_WIDTH        = 6,
    parameter int unsigned V_WIDTH        = 2,
    parameter int unsigned ADDR_BUS_WIDTH = 20
) (
    input  logic                      core_clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      advance,
    input  logic [N_WIDTH-1:0]        dim4,
    input  logic [M_WIDTH-1:0]        dim3,
    input  logic [E_WIDTH-1:0]        dim2,
    input  logic [F_WIDTH-1:0]        dim1,
    input  logic [V_WIDTH-1:0]        pad,
    input  logic [E_WIDTH-1:0]        ep,
    input  logic [F_WIDTH-1:0]        fp,
    output logic [ADDR_BUS_WIDTH-1:0] addr,
    output logic                      border_next,
    output logic [E_WIDTH:0]          skip_amount,
    output logic                      last
);

    localparam int unsigned SKIP_W = E_WIDTH + 1;

    logic [N_WIDTH-1:0]        r_n;
    logic [M_WIDTH-1:0]        r_m;
    logic [F_WIDTH-1:0]        r_x;
    logic [E_WIDTH-1:0]        r_y;
    logic [ADDR_BUS_WIDTH-1:0] r_addr;

    logic                      w_n_last;
    logic                      w_m_last;
    logic                      w_x_last;
    logic                      w_y_last;
    logic                      w_interior_col;
    logic [E_WIDTH-1:0]        w_y_top_last;
    logic [E_WIDTH-1:0]        w_y_bottom_first;

    // Wrap points of each nested counter.
    always_comb begin
        w_n_last = (r_n == dim4 - N_WIDTH'(1));
        w_m_last = (r_m == dim3 - M_WIDTH'(1));
        w_x_last = (r_x == fp - F_WIDTH'(1));
        w_y_last = (r_y == ep - E_WIDTH'(1));
    end

    // Interior columns are P <= x < P+F; their rows P..P+E-1 are skipped.
    always_comb begin
        w_interior_col   = (r_x >= F_WIDTH'(pad)) && (r_x < (F_WIDTH'(pad) + dim1));
        w_y_top_last     = E_WIDTH'(pad) - E_WIDTH'(1);
        w_y_bottom_first = E_WIDTH'(pad) + dim2;
        border_next      = !(w_interior_col && (r_y == w_y_top_last));
        skip_amount      = border_next ? SKIP_W'(1) : (SKIP_W'(dim2) + SKIP_W'(1));
        last             = w_n_last && w_m_last && w_x_last && w_y_last;
    end

    // Counter and address update; the address is a running sum, never a product.
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            r_n    <= '0;
            r_m    <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (clear) begin
            r_n    <= '0;
            r_m    <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (advance) begin
            r_addr <= r_addr + ADDR_BUS_WIDTH'(skip_amount);
            if (w_y_last) begin
                r_y <= '0;
                if (w_x_last) begin
                    r_x <= '0;
                    if (w_m_last) begin
                        r_m <= '0;
                        r_n <= w_n_last ? '0 : (r_n + N_WIDTH'(1));
                    end else begin
                        r_m <= r_m + M_WIDTH'(1);
                    end
                end else begin
                    r_x <= r_x + F_WIDTH'(1);
                end
            end else if (!border_next) begin
                r_y <= w_y_bottom_first;
            end else begin
                r_y <= r_y + E_WIDTH'(1);
            end
        end
    end

    assign addr = r_addr;

endmodule

// File: rtl/lrn_padding_unit.sv
// Zero-fills the border of every padded feature map in the LRN output
// buffer once the LRN mapper has written the interior pixels, then pulses
// padding_done to release the next layer stage.
//
// Ports
//   core_clk, reset      : clock, asynchronous active-high reset
//   start_padding        : start request, sampled only in IDLE
//   dim4/dim3/dim2/dim1  : N batches, M channels, E height, F width
//   padding_num          : P, pad rows/columns on each side
//   w_ready              : buffer accepts the current write
//   w_addr/w_data        : write address / data (data is always zero)
//   w_enable             : write request, high throughout PAD
//   busy                 : high in PAD and DONE
//   padding_done         : one-cycle completion pulse
module lrn_padding_unit
    import lrn_pkg::*;
#(
    parameter int unsigned N_WIDTH        = 2,
    parameter int unsigned M_WIDTH        = 10,
    parameter int unsigned E_WIDTH        = 6,
    parameter int unsigned F_WIDTH        = 6,
    parameter int unsigned V_WIDTH        = 2,
    parameter int unsigned ADDR_BUS_WIDTH = 20,
    parameter int unsigned DATA_WIDTH     = 16
) (
    input  logic                      core_clk,
    input  logic                      reset,
    input  logic                      start_padding,
    input  logic [N_WIDTH-1:0]        dim4,
    input  logic [M_WIDTH-1:0]        dim3,
    input  logic [E_WIDTH-1:0]        dim2,
    input  logic [F_WIDTH-1:0]        dim1,
    input  logic [V_WIDTH-1:0]        padding_num,
    input  logic                      w_ready,
    output logic [ADDR_BUS_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0]     w_data,
    output logic                      w_enable,
    output logic                      busy,
    output logic                      padding_done
);

    pad_state_t                r_state;
    logic [N_WIDTH-1:0]        r_dim4;
    logic [M_WIDTH-1:0]        r_dim3;
    logic [E_WIDTH-1:0]        r_dim2;
    logic [F_WIDTH-1:0]        r_dim1;
    logic [V_WIDTH-1:0]        r_pad;
    logic [E_WIDTH-1:0]        r_ep;
    logic [F_WIDTH-1:0]        r_fp;
    logic                      r_w_enable;
    logic                      r_busy;
    logic                      r_padding_done;

    logic [E_WIDTH-1:0]        w_ep;
    logic [F_WIDTH-1:0]        w_fp;
    logic                      w_scan_clear;
    logic                      w_scan_advance;
    logic                      w_scan_last;
    logic                      w_border_next;
    logic [E_WIDTH:0]          w_skip_amount;
    logic [ADDR_BUS_WIDTH-1:0] w_scan_addr;

    // Padded extents, computed at the unpadded widths (no overflow by contract).
    always_comb begin
        w_ep = dim2 + E_WIDTH'(padding_num) + E_WIDTH'(padding_num);
        w_fp = dim1 + F_WIDTH'(padding_num) + F_WIDTH'(padding_num);
    end

    assign w_scan_clear   = (r_state == IDLE) && start_padding;
    assign w_scan_advance = r_w_enable && w_ready;

    lrn_pad_scan_counter #(
        .N_WIDTH        (N_WIDTH),
        .M_WIDTH        (M_WIDTH),
        .E_WIDTH        (E_WIDTH),
        .F_WIDTH        (F_WIDTH),
        .V_WIDTH        (V_WIDTH),
        .ADDR_BUS_WIDTH (ADDR_BUS_WIDTH)
    ) u_scan (
        .core_clk    (core_clk),
        .reset       (reset),
        .clear       (w_scan_clear),
        .advance     (w_scan_advance),
        .dim4        (r_dim4),
        .dim3        (r_dim3),
        .dim2        (r_dim2),
        .dim1        (r_dim1),
        .pad         (r_pad),
        .ep          (r_ep),
        .fp          (r_fp),
        .addr        (w_scan_addr),
        .border_next (w_border_next),
        .skip_amount (w_skip_amount),
        .last        (w_scan_last)
    );

    // Sequencer and registered handshake/status outputs.
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_dim4         <= '0;
            r_dim3         <= '0;
            r_dim2         <= '0;
            r_dim1         <= '0;
            r_pad          <= '0;
            r_ep           <= '0;
            r_fp           <= '0;
            r_w_enable     <= 1'b0;
            r_busy         <= 1'b0;
            r_padding_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_padding_done <= 1'b0;
                    if (start_padding) begin
                        r_dim4 <= dim4;
                        r_dim3 <= dim3;
                        r_dim2 <= dim2;
                        r_dim1 <= dim1;
                        r_pad  <= padding_num;
                        r_ep   <= w_ep;
                        r_fp   <= w_fp;
                        r_busy <= 1'b1;
                        if (padding_num != '0) begin
                            r_state    <= PAD;
                            r_w_enable <= 1'b1;
                        end else begin
                            // Nothing to fill: report completion straight away.
                            r_state        <= DONE;
                            r_padding_done <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    if (w_ready && w_scan_last) begin
                        r_state        <= DONE;
                        r_w_enable     <= 1'b0;
                        r_padding_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state        <= IDLE;
                    r_busy         <= 1'b0;
                    r_padding_done <= 1'b0;
                end
                default: begin
                    r_state        <= IDLE;
                    r_w_enable     <= 1'b0;
                    r_busy         <= 1'b0;
                    r_padding_done <= 1'b0;
                end
            endcase
        end
    end

    // A row skip only ever happens mid-column and jumps exactly E+1 words.
    always_ff @(posedge core_clk) begin
        if (!reset && w_scan_advance && !w_border_next) begin
            assert ((w_skip_amount == ((E_WIDTH + 1)'(r_dim2) + (E_WIDTH + 1)'(1))) && !w_scan_last);
        end
    end

    assign w_addr       = w_scan_addr;
    assign w_data       = '0;
    assign w_enable     = r_w_enable;
    assign busy         = r_busy;
    assign padding_done = r_padding_done;

endmodule
